// File: rtl/io_controller.sv
// I/O request responder: executes OUT / IN / FINISH opcodes from the decoder,
// debounces the confirm button and stalls the core. Optional IN timeout: IO_TIMEOUT_EN.
module io_controller #(
  parameter int DATA_W          = 32,
  parameter int SW_W            = 16,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int TIMEOUT_CYCLES  = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        io_op,
  input  logic [DATA_W-1:0] out_data,
  input  logic [SW_W-1:0]   switches,
  input  logic              btn_confirm,
  input  logic              resume,
  output logic              stall,
  output logic [DATA_W-1:0] in_data,
  output logic              in_data_valid,
  output logic [DATA_W-1:0] display,
  output logic              out_strobe,
  output logic              finished,
  output logic              timeout_flag
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_PRESS, S_WAIT_RELEASE, S_DONE_IN, S_HALT
  } state_e;

  localparam logic [1:0] OP_NONE   = 2'b00;
  localparam logic [1:0] OP_OUT    = 2'b01;
  localparam logic [1:0] OP_IN     = 2'b10;
  localparam logic [1:0] OP_FINISH = 2'b11;

  localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  if (SW_W > DATA_W || DEBOUNCE_CYCLES < 2 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("io_controller: illegal parameter combination");
  end

  state_e            state_q, state_d;
  logic              btn_meta_q, btn_s_q, btn_db_q, btn_db_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic [DATA_W-1:0] display_q, display_d;
  logic [DATA_W-1:0] in_data_q, in_data_d;
  logic              out_strobe_q, out_strobe_d;
  logic              db_flip, press, release_evt;

`ifdef IO_TIMEOUT_EN
  localparam int              TO_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            timeout_flag_q, timeout_flag_d;
`endif

  // Debounced level only moves after DEBOUNCE_CYCLES consecutive disagreeing samples.
  assign db_flip     = (btn_s_q != btn_db_q) && (db_cnt_q == DB_LAST);
  assign press       = db_flip &  btn_s_q;
  assign release_evt = db_flip & ~btn_s_q;

  always_comb begin
    btn_db_d = btn_db_q;
    db_cnt_d = '0;
    if (btn_s_q != btn_db_q) begin
      if (db_cnt_q == DB_LAST) btn_db_d = btn_s_q;
      else                     db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    display_d     = display_q;
    in_data_d     = in_data_q;
    out_strobe_d  = 1'b0;
    stall         = 1'b0;
    in_data_valid = 1'b0;
    finished      = 1'b0;
`ifdef IO_TIMEOUT_EN
    to_cnt_d       = to_cnt_q;
    timeout_flag_d = timeout_flag_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        unique case (io_op)
          OP_NONE: ;
          OP_OUT: begin
            display_d    = out_data;
            out_strobe_d = 1'b1;
          end
          OP_IN: begin
            stall   = 1'b1;
            state_d = S_WAIT_PRESS;
`ifdef IO_TIMEOUT_EN
            to_cnt_d = '0;
`endif
          end
          OP_FINISH: begin
            stall   = 1'b1;
            state_d = S_HALT;
          end
        endcase
      end
      S_WAIT_PRESS: begin
        stall = 1'b1;
        if (press) begin
          in_data_d = DATA_W'(switches);
          state_d   = S_WAIT_RELEASE;
        end
`ifdef IO_TIMEOUT_EN
        else if (to_cnt_q == TO_LAST) begin
          in_data_d      = '0;
          timeout_flag_d = 1'b1;
          state_d        = S_DONE_IN;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
`endif
      end
      S_WAIT_RELEASE: begin
        stall = 1'b1;
        if (release_evt) state_d = S_DONE_IN;
      end
      S_DONE_IN: begin
        in_data_valid = 1'b1;
        state_d       = S_IDLE;
      end
      S_HALT: begin
        stall    = 1'b1;
        finished = 1'b1;
        if (resume) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (rst) begin
      stall         = 1'b0;
      in_data_valid = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      btn_meta_q   <= 1'b0;
      btn_s_q      <= 1'b0;
      btn_db_q     <= 1'b0;
      db_cnt_q     <= '0;
      display_q    <= '0;
      in_data_q    <= '0;
      out_strobe_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      btn_meta_q   <= btn_confirm;
      btn_s_q      <= btn_meta_q;
      btn_db_q     <= btn_db_d;
      db_cnt_q     <= db_cnt_d;
      display_q    <= display_d;
      in_data_q    <= in_data_d;
      out_strobe_q <= out_strobe_d;
    end
  end

`ifdef IO_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_q       <= '0;
      timeout_flag_q <= 1'b0;
    end else begin
      to_cnt_q       <= to_cnt_d;
      timeout_flag_q <= timeout_flag_d;
    end
  end
  assign timeout_flag = timeout_flag_q;
`else
  assign timeout_flag = 1'b0;
`endif

  assign in_data    = in_data_q;
  assign display    = display_q;
  assign out_strobe = out_strobe_q;

endmodule

// File: tb/tb_io_controller.sv
// Directed testbench for io_controller (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=64).
module tb_io_controller;

  localparam int DATA_W = 32;
  localparam int SW_W   = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        io_op;
  logic [DATA_W-1:0] out_data;
  logic [SW_W-1:0]   switches;
  logic              btn_confirm;
  logic              resume;
  logic              stall;
  logic [DATA_W-1:0] in_data;
  logic              in_data_valid;
  logic [DATA_W-1:0] display;
  logic              out_strobe;
  logic              finished;
  logic              timeout_flag;

  int checks = 0;
  int errors = 0;

  io_controller #(
    .DATA_W(DATA_W), .SW_W(SW_W), .DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(64)
  ) dut (
    .clk(clk), .rst(rst), .io_op(io_op), .out_data(out_data), .switches(switches),
    .btn_confirm(btn_confirm), .resume(resume), .stall(stall), .in_data(in_data),
    .in_data_valid(in_data_valid), .display(display), .out_strobe(out_strobe),
    .finished(finished), .timeout_flag(timeout_flag)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; io_op = 2'b10; out_data = '0; switches = '0; btn_confirm = 1'b0; resume = 1'b0;
    tick(); tick();
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall_forced got %b want 0", stall); end
    checks++; if (display !== 32'h0) begin errors++; $display("FAIL reset_display got %h want 0", display); end
    checks++; if (in_data !== 32'h0) begin errors++; $display("FAIL reset_in_data got %h want 0", in_data); end
    checks++; if (in_data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", in_data_valid); end
    checks++; if (out_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe got %b want 0", out_strobe); end
    checks++; if (finished !== 1'b0) begin errors++; $display("FAIL reset_finished got %b want 0", finished); end
    checks++; if (timeout_flag !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b want 0", timeout_flag); end
    io_op = 2'b00; rst = 1'b0;
    tick();
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL idle_stall got %b want 0", stall); end
  endtask

  task automatic test_out();
    out_data = 32'hDEADBEEF; io_op = 2'b01;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL out_stall got %b want 0", stall); end
    checks++; if (out_strobe !== 1'b0) begin errors++; $display("FAIL out_strobe_early got %b want 0", out_strobe); end
    tick();
    io_op = 2'b00; out_data = 32'h12345678;
    #1;
    checks++; if (display !== 32'hDEADBEEF) begin errors++; $display("FAIL out_display got %h want deadbeef", display); end
    checks++; if (out_strobe !== 1'b1) begin errors++; $display("FAIL out_strobe got %b want 1", out_strobe); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL out_stall_after got %b want 0", stall); end
    tick();
    checks++; if (out_strobe !== 1'b0) begin errors++; $display("FAIL out_strobe_width got %b want 0", out_strobe); end
    checks++; if (display !== 32'hDEADBEEF) begin errors++; $display("FAIL out_display_hold got %h want deadbeef", display); end
  endtask

  task automatic test_in();
    bit seen;
    // Button held and settled before IN is issued: must not count as a press.
    btn_confirm = 1'b1;
    repeat (10) tick();
    switches = 16'hA5C3; io_op = 2'b10;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL in_stall_same_cycle got %b want 1", stall); end
    for (int i = 0; i < 15; i++) begin
      tick();
      checks++;
      if (stall !== 1'b1 || in_data_valid !== 1'b0) begin
        errors++; $display("FAIL in_held_wait cyc %0d stall %b valid %b want 1/0", i, stall, in_data_valid);
      end
    end
    checks++; if (in_data !== 32'h0) begin errors++; $display("FAIL in_held_no_capture got %h want 0", in_data); end
    btn_confirm = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL in_release_wait cyc %0d stall %b want 1", i, stall); end
    end
    btn_confirm = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL in_press_stall cyc %0d stall %b want 1", i, stall); end
    end
    btn_confirm = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      tick();
      if (in_data_valid === 1'b1) seen = 1'b1;
      else begin
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL in_release_stall cyc %0d stall %b want 1", i, stall); end
      end
    end
    checks++; if (!seen) begin errors++; $display("FAIL in_valid_timeout got none want pulse"); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL in_valid_stall got %b want 0", stall); end
    checks++; if (in_data !== 32'h0000A5C3) begin errors++; $display("FAIL in_data got %h want 0000a5c3", in_data); end
    io_op = 2'b00;
    tick();
    checks++; if (in_data_valid !== 1'b0) begin errors++; $display("FAIL in_valid_width got %b want 0", in_data_valid); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL in_after_stall got %b want 0", stall); end
    checks++; if (in_data !== 32'h0000A5C3) begin errors++; $display("FAIL in_data_hold got %h want 0000a5c3", in_data); end
  endtask

  task automatic test_bounce();
    int k;
    int pulses;
    bit seen;
    switches = 16'h1234; io_op = 2'b10;
    tick();
    for (int i = 0; i < 20; i++) begin
      btn_confirm = ((i / 2) % 2) == 0;
      tick();
      checks++;
      if (in_data !== 32'h0000A5C3 || stall !== 1'b1) begin
        errors++; $display("FAIL bounce_no_capture cyc %0d in_data %h stall %b want 0000a5c3/1", i, in_data, stall);
      end
    end
    btn_confirm = 1'b1;
    k = 0;
    while (k < 20 && in_data === 32'h0000A5C3) begin
      tick();
      k++;
    end
    checks++; if (k !== 6) begin errors++; $display("FAIL bounce_accept_latency got %0d want 6", k); end
    checks++; if (in_data !== 32'h00001234) begin errors++; $display("FAIL bounce_capture got %h want 00001234", in_data); end
    btn_confirm = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      tick();
      if (in_data_valid === 1'b1) seen = 1'b1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL bounce_valid_timeout got none want pulse"); end
    io_op = 2'b00;
    pulses = 0;
    repeat (10) begin
      tick();
      if (in_data_valid === 1'b1) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL bounce_extra_valid got %0d want 0", pulses); end
  endtask

  task automatic test_finish();
    io_op = 2'b11;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL fin_stall_same_cycle got %b want 1", stall); end
    tick();
    for (int i = 0; i < 100; i++) begin
      btn_confirm = ((i / 8) % 2) == 1;
      checks++;
      if (stall !== 1'b1 || finished !== 1'b1 || in_data_valid !== 1'b0) begin
        errors++; $display("FAIL fin_hold cyc %0d stall %b fin %b valid %b want 1/1/0", i, stall, finished, in_data_valid);
      end
      tick();
    end
    checks++; if (in_data !== 32'h00001234) begin errors++; $display("FAIL fin_in_data_hold got %h want 00001234", in_data); end
    btn_confirm = 1'b0; io_op = 2'b00; resume = 1'b1;
    #1;
    checks++; if (finished !== 1'b1) begin errors++; $display("FAIL fin_resume_cycle got %b want 1", finished); end
    tick();
    resume = 1'b0;
    checks++; if (finished !== 1'b0) begin errors++; $display("FAIL fin_released got %b want 0", finished); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL fin_stall_released got %b want 0", stall); end
    repeat (10) tick();
  endtask

  task automatic test_resume_idle();
    resume = 1'b1;
    tick();
    resume = 1'b0;
    checks++; if (finished !== 1'b0 || stall !== 1'b0) begin
      errors++; $display("FAIL resume_idle fin %b stall %b want 0/0", finished, stall);
    end
    tick();
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL resume_idle_after got %b want 0", stall); end
  endtask

`ifdef IO_TIMEOUT_EN
  task automatic test_timeout();
    int k;
    io_op = 2'b10;
    k = 0;
    while (k < 100 && in_data_valid !== 1'b1) begin
      tick();
      k++;
    end
    checks++; if (k !== 65) begin errors++; $display("FAIL to_latency got %0d want 65", k); end
    checks++; if (in_data !== 32'h0) begin errors++; $display("FAIL to_in_data got %h want 0", in_data); end
    checks++; if (timeout_flag !== 1'b1) begin errors++; $display("FAIL to_flag got %b want 1", timeout_flag); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL to_stall got %b want 0", stall); end
    io_op = 2'b00;
    repeat (5) tick();
    checks++; if (timeout_flag !== 1'b1) begin errors++; $display("FAIL to_sticky got %b want 1", timeout_flag); end
  endtask
`else
  task automatic test_timeout();
    checks++; if (timeout_flag !== 1'b0) begin errors++; $display("FAIL to_tied_off got %b want 0", timeout_flag); end
  endtask
`endif

  task automatic test_reset_mid_in();
    bit captured;
    int pulses;
    switches = 16'h00FF; io_op = 2'b10;
    tick();
    btn_confirm = 1'b1;
    captured = 1'b0;
    for (int i = 0; i < 20 && !captured; i++) begin
      tick();
      if (in_data === 32'h000000FF) captured = 1'b1;
    end
    checks++; if (!captured) begin errors++; $display("FAIL rmid_capture got %h want 000000ff", in_data); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rmid_stall_before got %b want 1", stall); end
    rst = 1'b1; io_op = 2'b00;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rmid_stall_in_reset got %b want 0", stall); end
    tick();
    rst = 1'b0; btn_confirm = 1'b0;
    #1;
    checks++; if (in_data !== 32'h0) begin errors++; $display("FAIL rmid_in_data got %h want 0", in_data); end
    checks++; if (display !== 32'h0) begin errors++; $display("FAIL rmid_display got %h want 0", display); end
    checks++; if (stall !== 1'b0 || finished !== 1'b0 || out_strobe !== 1'b0 || timeout_flag !== 1'b0) begin
      errors++; $display("FAIL rmid_outputs stall %b fin %b strobe %b to %b want 0", stall, finished, out_strobe, timeout_flag);
    end
    pulses = 0;
    repeat (20) begin
      if (in_data_valid === 1'b1) pulses++;
      tick();
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL rmid_valid got %0d want 0", pulses); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_out();
    test_in();
    test_bounce();
    test_finish();
    test_resume_idle();
    test_timeout();
    test_reset_mid_in();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/io_controller.md
Name: io_controller

Overview:
- Responder side of the processor's I/O request interface: executes the 2-bit I/O opcode (00 none, 01 OUT, 10 IN, 11 FINISH) issued each cycle by the instruction decoder.
- IN: stalls the core until the user confirms the switch value with a debounced button, then returns the value for register writeback.
- OUT: latches a register value onto the display register.
- FINISH: halts the core until a resume pulse arrives.

Parameters:
DATA_W, 32, datapath width of out_data, in_data, display
SW_W, 16, switch input width; zero-extended to DATA_W (SW_W <= DATA_W)
DEBOUNCE_CYCLES, 50000, consecutive stable cycles required to accept a button level change (>= 2)
TIMEOUT_CYCLES, 1000000, IN wait limit; used only with IO_TIMEOUT_EN

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
io_op  input  2  I/O opcode from decoder: 00 none, 01 OUT, 10 IN, 11 FINISH
out_data  input  DATA_W  register value to display on OUT
switches  input  SW_W  raw switch levels, sampled on accepted press
btn_confirm  input  1  raw asynchronous confirm button, active-high
resume  input  1  one-cycle pulse; releases HALT
stall  output  1  hold PC and suppress writes (combinational)
in_data  output  DATA_W  captured input value, zero-extended
in_data_valid  output  1  one-cycle pulse; core writes in_data this cycle
display  output  DATA_W  display register
out_strobe  output  1  one-cycle pulse after display update
finished  output  1  high while in HALT
timeout_flag  output  1  sticky IN-timeout indicator

Behaviour:
- Reset (rst high at edge): state=IDLE; display=0, in_data=0, in_data_valid=0, out_strobe=0, finished=0, timeout_flag=0. Sync flops, debounced level and counter are cleared. stall is forced 0 while rst=1. Reset mid-IN or mid-HALT aborts the operation; no in_data_valid is issued.
- Button path:
  - 2-flop synchronizer gives btn_s.
  - Counter increments while btn_s != btn_db and clears otherwise.
  - When the counter reaches DEBOUNCE_CYCLES-1, btn_db <= btn_s and the counter clears.
  - press = btn_db rising; release = btn_db falling.
  - The debouncer runs in every state.
- States: IDLE, WAIT_PRESS, WAIT_RELEASE, DONE_IN, HALT.
- IDLE:
  - io_op=00: no action.
  - io_op=01: display<=out_data at the edge; out_strobe=1 the next cycle; no stall (zero-latency OUT).
  - io_op=10: stall=1 in the same cycle; next state WAIT_PRESS.
  - io_op=11: stall=1 in the same cycle; next state HALT.
- WAIT_PRESS: stall=1. On press, in_data<={zero,switches}; next state WAIT_RELEASE. A button already held when IN starts does not count; a fresh rising edge of btn_db is required.
- WAIT_RELEASE: stall=1. On release, next state DONE_IN.
- DONE_IN: stall=0, in_data_valid=1 for exactly one cycle; the core commits the IN instruction at this edge. Next state IDLE. io_op is ignored in this cycle.
- HALT: stall=1, finished=1. io_op and the button are ignored. On resume=1, next state IDLE, with finished=0 from the next cycle.
- io_op is sampled only in IDLE. Non-IDLE states ignore it, because the core holds the same instruction while stalled.
- A resume pulse outside HALT is ignored.
- in_data and display hold their values until the next IN or OUT, respectively.

Optional Feature:
- Macro: IO_TIMEOUT_EN.
- When defined:
  - A counter clears on entry to WAIT_PRESS.
  - If TIMEOUT_CYCLES cycles elapse without a press: in_data<=0, timeout_flag<=1 (sticky until reset), next state DONE_IN. The normal one-cycle writeback follows.
  - A press in the same cycle as expiry takes priority: switches are captured and there is no timeout.
- When not defined: WAIT_PRESS waits indefinitely; timeout_flag is tied 0; TIMEOUT_CYCLES is unused.

Test Plan:
- Bench setup: DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=64.
- OUT: out_data=32'hDEADBEEF, io_op=01 for 1 cycle -> display=32'hDEADBEEF after the edge; out_strobe high exactly 1 cycle; stall never high.
- IN: switches=16'hA5C3, io_op=10 held, clean press 10 cycles then release -> stall high from the IN cycle through WAIT_RELEASE; in_data=32'h0000A5C3; in_data_valid single pulse with stall=0.
- Bounce: button toggling every 2 cycles for 20 cycles, then stable high -> one press accepted only after 4 stable cycles; a single capture.
- FINISH: io_op=11 -> stall=1 and finished=1 held 100 cycles with button activity ignored; resume pulse -> IDLE, stall=0, finished=0.
- Reset mid-IN: rst during WAIT_RELEASE -> all outputs at reset values next cycle; no in_data_valid.
- IO_TIMEOUT_EN: IN with no press -> in_data_valid after 64 WAIT_PRESS cycles, in_data=0, timeout_flag=1 and sticky.
